// File: rtl/pwm_time_base.sv
// Timer time base: prescaler, up/down/center-aligned auto-reload counter, update events
// and UEV-loaded shadow registers feeding the downstream pwm_comparator stage.
module pwm_time_base #(
  parameter int CNT_WIDTH = 16,
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic                 arpe_i,
  input  logic [CNT_WIDTH-1:0] cmp_start_i,
  input  logic [CNT_WIDTH-1:0] cmp_end_i,
  input  logic                 ug_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cmp_start_o,
  output logic [CNT_WIDTH-1:0] cmp_end_o,
  output logic                 dir_o,
  output logic                 psc_tick_o,
  output logic                 uev_o,
  output logic                 ovf_o,
  output logic                 unf_o
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_CENTER = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

  logic [PSC_WIDTH-1:0] psc_cnt;
  logic [PSC_WIDTH-1:0] psc_shadow;
  logic [CNT_WIDTH-1:0] arr_shadow;
  mode_t                mode_shadow;

  logic                 tick;
  logic [PSC_WIDTH-1:0] psc_next;
  logic [CNT_WIDTH-1:0] arr_act;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 dir_next;
  logic                 ovf_next;
  logic                 unf_next;
  logic                 uev_next;

  assign arr_act = arpe_i ? arr_shadow : arr_i;

  // Next-state for prescaler and counter; flags are evaluated with the
  // shadows currently in force, so a reload only affects the following tick.
  always_comb begin
    tick     = en_i && (psc_cnt == psc_shadow);
    psc_next = psc_cnt;
    cnt_next = cnt_o;
    dir_next = dir_o;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (en_i) begin
      psc_next = tick ? '0 : psc_cnt + PSC_ONE;
    end
    if (tick) begin
      case (mode_shadow)
        MODE_DOWN: begin
          dir_next = 1'b1;
          if (cnt_o == '0) begin
            cnt_next = arr_act;
            unf_next = 1'b1;
          end else begin
            cnt_next = cnt_o - CNT_ONE;
          end
        end
        MODE_CENTER: begin
          if (arr_act == '0) begin
            cnt_next = '0;
            dir_next = 1'b0;
            ovf_next = 1'b1;
          end else if (!dir_o) begin
            if (cnt_o >= arr_act) begin
              dir_next = 1'b1;
              cnt_next = cnt_o - CNT_ONE;
              ovf_next = 1'b1;
            end else begin
              cnt_next = cnt_o + CNT_ONE;
            end
          end else if (cnt_o == '0) begin
            dir_next = 1'b0;
            cnt_next = cnt_o + CNT_ONE;
            unf_next = 1'b1;
          end else begin
            cnt_next = cnt_o - CNT_ONE;
          end
        end
        default: begin
          dir_next = 1'b0;
          if (cnt_o >= arr_act) begin
            cnt_next = '0;
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_o + CNT_ONE;
          end
        end
      endcase
    end
    uev_next = ovf_next | unf_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_cnt     <= '0;
      psc_shadow  <= '0;
      arr_shadow  <= '0;
      mode_shadow <= MODE_UP;
      cnt_o       <= '0;
      cmp_start_o <= '0;
      cmp_end_o   <= '0;
      dir_o       <= 1'b0;
      psc_tick_o  <= 1'b0;
      uev_o       <= 1'b0;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
    end else if (ug_i) begin
      // Software update: restart the period from scratch, dropping any tick.
      psc_cnt     <= '0;
      psc_shadow  <= psc_i;
      arr_shadow  <= arr_i;
      mode_shadow <= mode_t'(mode_i);
      cmp_start_o <= cmp_start_i;
      cmp_end_o   <= cmp_end_i;
      dir_o       <= 1'b0;
      cnt_o       <= (mode_t'(mode_i) == MODE_DOWN) ? arr_i : '0;
      psc_tick_o  <= 1'b0;
      uev_o       <= 1'b1;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
    end else begin
      psc_cnt    <= psc_next;
      cnt_o      <= cnt_next;
      dir_o      <= dir_next;
      psc_tick_o <= tick;
      uev_o      <= uev_next;
      ovf_o      <= ovf_next;
      unf_o      <= unf_next;
      if (uev_next) begin
        psc_shadow  <= psc_i;
        arr_shadow  <= arr_i;
        mode_shadow <= mode_t'(mode_i);
        cmp_start_o <= cmp_start_i;
        cmp_end_o   <= cmp_end_i;
      end
    end
  end

endmodule

// File: tb/tb_pwm_time_base.sv
// Bench for pwm_time_base: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the timer rules.
module tb_pwm_time_base;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] psc;
  logic [15:0] arr;
  logic        arpe;
  logic [15:0] cs;
  logic [15:0] ce;
  logic        ug;
  logic [15:0] cnt_o;
  logic [15:0] cmp_start_o;
  logic [15:0] cmp_end_o;
  logic        dir_o;
  logic        psc_tick_o;
  logic        uev_o;
  logic        ovf_o;
  logic        unf_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_cnt, m_dir, m_psc_cnt, m_psc_sh, m_arr_sh, m_mode_sh, m_cs, m_ce;
  int m_tick, m_uev, m_ovf, m_unf;

  pwm_time_base #(.CNT_WIDTH(16), .PSC_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .psc_i(psc),
    .arr_i(arr), .arpe_i(arpe), .cmp_start_i(cs), .cmp_end_i(ce), .ug_i(ug),
    .cnt_o(cnt_o), .cmp_start_o(cmp_start_o), .cmp_end_o(cmp_end_o),
    .dir_o(dir_o), .psc_tick_o(psc_tick_o), .uev_o(uev_o), .ovf_o(ovf_o),
    .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_shadows();
    m_psc_sh  = int'(psc);
    m_arr_sh  = int'(arr);
    m_mode_sh = (mode == 2'b11) ? 0 : int'(mode);
    m_cs      = int'(cs);
    m_ce      = int'(ce);
  endtask

  // One clock of the timer rules, using the inputs present at the edge.
  task automatic model_step();
    int limit;
    m_tick = 0; m_uev = 0; m_ovf = 0; m_unf = 0;
    if (rst) begin
      m_cnt = 0; m_dir = 0; m_psc_cnt = 0; m_psc_sh = 0; m_arr_sh = 0;
      m_mode_sh = 0; m_cs = 0; m_ce = 0;
    end else if (ug) begin
      load_shadows();
      m_psc_cnt = 0;
      m_dir = 0;
      m_cnt = (mode == 2'b01) ? int'(arr) : 0;
      m_uev = 1;
    end else if (en) begin
      if (m_psc_cnt == m_psc_sh) begin
        m_psc_cnt = 0;
        m_tick = 1;
      end else begin
        m_psc_cnt++;
      end
      if (m_tick == 1) begin
        limit = arpe ? m_arr_sh : int'(arr);
        if (m_mode_sh == 1) begin
          m_dir = 1;
          if (m_cnt == 0) begin m_cnt = limit; m_unf = 1; end
          else m_cnt--;
        end else if (m_mode_sh == 2) begin
          if (limit == 0) begin m_cnt = 0; m_dir = 0; m_ovf = 1; end
          else if (m_dir == 0 && m_cnt >= limit) begin m_dir = 1; m_cnt--; m_ovf = 1; end
          else if (m_dir == 0) m_cnt++;
          else if (m_cnt == 0) begin m_dir = 0; m_cnt = 1; m_unf = 1; end
          else m_cnt--;
        end else begin
          m_dir = 0;
          if (m_cnt >= limit) begin m_cnt = 0; m_ovf = 1; end
          else m_cnt++;
        end
        m_uev = m_ovf | m_unf;
        if (m_uev == 1) load_shadows();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("cnt", 32'(cnt_o), 32'(m_cnt));
    check("dir", 32'(dir_o), 32'(m_dir));
    check("tick", 32'(psc_tick_o), 32'(m_tick));
    check("uev", 32'(uev_o), 32'(m_uev));
    check("ovf", 32'(ovf_o), 32'(m_ovf));
    check("unf", 32'(unf_o), 32'(m_unf));
    check("cmp_start", 32'(cmp_start_o), 32'(m_cs));
    check("cmp_end", 32'(cmp_end_o), 32'(m_ce));
  endtask

  task automatic pulse_ug();
    ug = 1'b1;
    cycle();
    ug = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int found;
    rst = 1'b1; en = 1'b0; mode = 2'b00; psc = '0; arr = '0; arpe = 1'b0;
    cs = '0; ce = '0; ug = 1'b0;
    cycle();
    cycle();
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_uev", 32'(uev_o), 32'd0);
    check("rst_cmp_end", 32'(cmp_end_o), 32'd0);

    // Up counting, no prescale
    rst = 1'b0; psc = 16'd0; arr = 16'd3; mode = 2'b00; en = 1'b1;
    cs = 16'd1; ce = 16'd2;
    pulse_ug();
    check("up_ug_cnt", 32'(cnt_o), 32'd0);
    check("up_ug_uev", 32'(uev_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_cnt = (i + 1) % 4;
      check("up_seq", 32'(cnt_o), 32'(exp_cnt));
      check("up_ovf", 32'(ovf_o), 32'(exp_cnt == 0));
      check("up_tick", 32'(psc_tick_o), 32'd1);
    end

    // Prescaled up counting
    psc = 16'd2; arr = 16'd2;
    pulse_ug();
    repeat (20) cycle();

    // Center-aligned triangle 0..3..0
    psc = 16'd0; arr = 16'd3; mode = 2'b10;
    pulse_ug();
    for (int i = 1; i <= 12; i++) begin
      cycle();
      exp_cnt = ((i % 6) <= 3) ? (i % 6) : 6 - (i % 6);
      check("ctr_seq", 32'(cnt_o), 32'(exp_cnt));
    end

    // Preloaded ARR and compare, then direct ARR decrease
    mode = 2'b00; arpe = 1'b1; arr = 16'd3; cs = 16'd1;
    pulse_ug();
    cycle();
    cycle();
    arr = 16'd5; cs = 16'd2;
    cycle();
    check("pre_cnt3", 32'(cnt_o), 32'd3);
    check("pre_cs_old", 32'(cmp_start_o), 32'd1);
    cycle();
    check("pre_wrap", 32'(cnt_o), 32'd0);
    check("pre_cs_new", 32'(cmp_start_o), 32'd2);
    arpe = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (m_cnt == 4) found = 1;
      else cycle();
    end
    check("wait_cnt4", 32'(found), 32'd1);
    arr = 16'd1;
    cycle();
    check("arr_dec_wrap", 32'(cnt_o), 32'd0);
    check("arr_dec_ovf", 32'(ovf_o), 32'd1);

    // Down counting
    arr = 16'd4; mode = 2'b01;
    pulse_ug();
    check("dn_ug_cnt", 32'(cnt_o), 32'd4);
    repeat (12) cycle();
    check("dn_dir", 32'(dir_o), 32'd1);

    // ug with enable low, then reset mid-count
    mode = 2'b00; arr = 16'd5;
    pulse_ug();
    cycle();
    cycle();
    en = 1'b0;
    repeat (3) cycle();
    check("hold_cnt", 32'(cnt_o), 32'd2);
    cs = 16'd7; arr = 16'd6;
    pulse_ug();
    check("ug_off_cnt", 32'(cnt_o), 32'd0);
    check("ug_off_uev", 32'(uev_o), 32'd1);
    check("ug_off_cs", 32'(cmp_start_o), 32'd7);
    cycle();
    check("ug_off_uev_clr", 32'(uev_o), 32'd0);
    en = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_cnt", 32'(cnt_o), 32'd0);
    check("mid_rst_cs", 32'(cmp_start_o), 32'd0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      ug   = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 9) != 0);
      mode = 2'($urandom_range(0, 3));
      psc  = 16'($urandom_range(0, 3));
      arr  = 16'($urandom_range(0, 7));
      arpe = 1'($urandom_range(0, 1));
      cs   = 16'($urandom);
      ce   = 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
